// File: rtl/trojan_seq_injector_if.sv
// trojan_seq_injector_if: control+handshake bundle (start, abort, out_ready, out_valid, out_data[127:0], seq_idx[1:0], busy, done) between host, injector and AES input
interface trojan_seq_injector_if;
  logic         start;
  logic         abort;
  logic         out_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic [1:0]   seq_idx;
  logic         busy;
  logic         done;
  modport master(input start, abort, out_ready, output out_valid, out_data, seq_idx, busy, done);
  modport slave(output start, abort, out_ready, input out_valid, out_data, seq_idx, busy, done);
endinterface

// File: rtl/trojan_seq_injector.sv
// trojan_seq_injector: issues W0..W3 with a GAP_CYCLES idle gap between words; ports clk, rst (async high), bus (start/abort/out_ready in; out_valid/out_data/seq_idx/busy/done out, all registered)
module trojan_seq_injector #(
  parameter logic [127:0] W0 = 128'h3243f6a8_885a308d_313198a2_e0370734,
  parameter logic [127:0] W1 = 128'h00112233_44556677_8899aabb_ccddeeff,
  parameter logic [127:0] W2 = 128'h0,
  parameter logic [127:0] W3 = 128'h1,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  trojan_seq_injector_if.master bus
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES);
  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [1:0]   idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] data_q, data_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
      idx_d = 2'd0;
      cnt_d = 8'd0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) state_d = SEND;
        SEND: if (bus.out_ready) begin
          if (idx_q == 2'd3) state_d = DONE;
          else if (GAP_LD == 8'd0) idx_d = idx_q + 2'd1;
          else begin
            state_d = GAP;
            cnt_d = GAP_LD;
          end
        end
        GAP: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_d = SEND;
            idx_d = idx_q + 2'd1;
            cnt_d = 8'd0;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d = 2'd0;
        end
      endcase
    end
    valid_d = state_d == SEND;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
    data_d = !valid_d ? 128'h0 : idx_d == 2'd0 ? W0 : idx_d == 2'd1 ? W1 : idx_d == 2'd2 ? W2 : W3;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      idx_q <= 2'd0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= 128'h0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      data_q <= data_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.out_data = data_q;
  assign bus.seq_idx = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule
